// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: command, unit-drive and response signals of the ALU op issuer.
interface alu_op_issuer_if #(parameter int DATA_WIDTH = 16);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;
    logic [DATA_WIDTH-1:0] alu_in1;
    logic [DATA_WIDTH-1:0] alu_in2;
    logic [1:0]            alu_fun;
    logic [3:0]            unit_en;
    logic [DATA_WIDTH-1:0] unit_out;
    logic                  unit_flag;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  busy;
    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, unit_out, unit_flag, rsp_ready,
        output cmd_ready, alu_in1, alu_in2, alu_fun, unit_en, rsp_valid, rsp_data, rsp_err, busy
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, unit_out, unit_flag, rsp_ready,
        input  cmd_ready, alu_in1, alu_in2, alu_fun, unit_en, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues one ALU op per command to a one-hot unit and returns its result.
module alu_op_issuer #(
    parameter int         DATA_WIDTH  = 16,
    parameter int         TIMEOUT_CYC = 4,
    parameter logic [3:0] UNIT_MASK   = 4'b1111
) (
    input  logic clk,
    input  logic rst_n,
    alu_op_issuer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [DATA_WIDTH-1:0] in1_d, in2_d, data_d;
    logic [1:0]            fun_d;
    logic [3:0]            en_d;
    logic                  err_d, present, timeout, accept, done, fail;
    assign present = UNIT_MASK[bus.cmd_op[3:2]];
    assign timeout = cnt == CW'(TIMEOUT_CYC - 1);
    assign accept  = state == IDLE && bus.cmd_valid;
    assign done    = state == RESP && bus.rsp_ready;
    assign fail    = (accept && !present) || (state == WAIT && !bus.unit_flag && timeout);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.cmd_ready <= 1'b1;
            bus.unit_en   <= '0;
            bus.alu_in1   <= '0;
            bus.alu_in2   <= '0;
            bus.alu_fun   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            bus.cmd_ready <= state_d == IDLE;
            bus.unit_en   <= en_d;
            bus.alu_in1   <= in1_d;
            bus.alu_in2   <= in2_d;
            bus.alu_fun   <= fun_d;
            bus.rsp_valid <= state_d == RESP;
            bus.rsp_data  <= data_d;
            bus.rsp_err   <= err_d;
            bus.busy      <= state_d != IDLE;
        end
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_d = present ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.unit_flag || timeout) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Operands stay on the unit bus from accept until the response is taken.
    always_comb begin
        in1_d  = accept ? bus.cmd_a       : done ? '0 : bus.alu_in1;
        in2_d  = accept ? bus.cmd_b       : done ? '0 : bus.alu_in2;
        fun_d  = accept ? bus.cmd_op[1:0] : done ? '0 : bus.alu_fun;
        en_d   = (accept && present) ? 4'b0001 << bus.cmd_op[3:2] : 4'b0000;
        cnt_d  = state == WAIT ? cnt + 1'b1 : '0;
        data_d = (state == WAIT && bus.unit_flag) ? bus.unit_out : fail ? '0 : bus.rsp_data;
        err_d  = (state == WAIT && bus.unit_flag) ? 1'b0 : fail ? 1'b1 : bus.rsp_err;
    end
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed checks of the ALU op issuer against a registered unit model.
module tb_alu_op_issuer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic u_flag, stray, mute;
    logic [15:0] u_out, res;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    alu_op_issuer_if #(.DATA_WIDTH(16)) bus ();
    alu_op_issuer #(.DATA_WIDTH(16), .TIMEOUT_CYC(4), .UNIT_MASK(4'b0011)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // Unit model: arith (unit 0) adds, logic (unit 1) AND/OR/XOR/NOR; result registered.
    always_comb begin
        res = '0;
        if (bus.unit_en[0]) res = bus.alu_in1 + bus.alu_in2;
        if (bus.unit_en[1])
            res = bus.alu_fun == 2'd0 ? bus.alu_in1 & bus.alu_in2 :
                  bus.alu_fun == 2'd1 ? bus.alu_in1 | bus.alu_in2 :
                  bus.alu_fun == 2'd2 ? bus.alu_in1 ^ bus.alu_in2 : ~(bus.alu_in1 | bus.alu_in2);
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_flag <= 1'b0;
            u_out  <= '0;
        end else begin
            u_flag <= |bus.unit_en && !mute;
            u_out  <= (|bus.unit_en && !mute) ? res : 16'h0;
        end
    end
    assign bus.unit_out  = u_out;
    assign bus.unit_flag = u_flag | stray;

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    task automatic test_reset;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_ready_busy: got %b/%b expected 1/0", bus.cmd_ready, bus.busy);
        end
        checks++;
        if (bus.unit_en !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_en_rsp: got en=%b v=%b e=%b expected 0", bus.unit_en, bus.rsp_valid, bus.rsp_err);
        end
        checks++;
        if (bus.rsp_data !== 16'h0 || bus.alu_in1 !== 16'h0 || bus.alu_in2 !== 16'h0 || bus.alu_fun !== 2'b0) begin
            errors++; $display("FAIL reset_data: got d=%h in1=%h in2=%h fun=%b expected 0", bus.rsp_data, bus.alu_in1, bus.alu_in2, bus.alu_fun);
        end
    endtask

    task automatic test_logic_and;
        bus.rsp_ready = 1'b1;
        send(4'b0100, 16'hF0F0, 16'h0FF0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.unit_en !== 4'b0010 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL and_issue: got en=%b rdy=%b busy=%b expected 0010/0/1", bus.unit_en, bus.cmd_ready, bus.busy);
        end
        checks++;
        if (bus.alu_in1 !== 16'hF0F0 || bus.alu_in2 !== 16'h0FF0 || bus.alu_fun !== 2'b00) begin
            errors++; $display("FAIL and_operands: got %h %h %b expected f0f0 0ff0 00", bus.alu_in1, bus.alu_in2, bus.alu_fun);
        end
        @(negedge clk);
        checks++;
        if (bus.unit_en !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.alu_in1 !== 16'hF0F0) begin
            errors++; $display("FAIL and_wait: got en=%b v=%b in1=%h expected 0000/0/f0f0", bus.unit_en, bus.rsp_valid, bus.alu_in1);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h00F0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL and_rsp: got v=%b d=%h e=%b expected 1/00f0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.alu_in1 !== 16'h0 || bus.alu_fun !== 2'b0) begin
            errors++; $display("FAIL and_done: got v=%b rdy=%b in1=%h fun=%b expected 0/1/0/0", bus.rsp_valid, bus.cmd_ready, bus.alu_in1, bus.alu_fun);
        end
    endtask

    task automatic test_timeout;
        int w = 0;
        mute = 1'b1;
        bus.rsp_ready = 1'b1;
        send(4'b0000, 16'h0001, 16'h0002);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.unit_en !== 4'b0001) begin
            errors++; $display("FAIL to_issue: got %b expected 0001", bus.unit_en);
        end
        @(negedge clk);
        while (!bus.rsp_valid && w < 20) begin
            w++;
            @(negedge clk);
        end
        checks++;
        if (w !== 4) begin
            errors++; $display("FAIL to_wait_cycles: got %0d expected 4", w);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 16'h0) begin
            errors++; $display("FAIL to_rsp: got v=%b e=%b d=%h expected 1/1/0000", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        @(negedge clk);
        mute = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL to_done: got v=%b busy=%b expected 0/0", bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_backpressure;
        int w = 0;
        bus.rsp_ready = 1'b0;
        send(4'b0100, 16'hF0F0, 16'h0FF0);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.unit_en !== 4'b0010) begin
            errors++; $display("FAIL bp_issue: got rdy=%b en=%b expected 0/0010", bus.cmd_ready, bus.unit_en);
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h00F0 || bus.cmd_ready !== 1'b0 || bus.unit_en !== 4'b0) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b en=%b expected 1/00f0/0/0000", i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, bus.unit_en);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.unit_en !== 4'b0) begin
            errors++; $display("FAIL bp_release: got v=%b rdy=%b en=%b expected 0/1/0000", bus.rsp_valid, bus.cmd_ready, bus.unit_en);
        end
        @(negedge clk);
        checks++;
        if (bus.unit_en !== 4'b0010) begin
            errors++; $display("FAIL bp_reaccept: got %b expected 0010", bus.unit_en);
        end
        bus.cmd_valid = 1'b0;
        while (!bus.rsp_valid && w < 10) begin
            w++;
            @(negedge clk);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h00F0) begin
            errors++; $display("FAIL bp_second: got v=%b d=%h expected 1/00f0", bus.rsp_valid, bus.rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_absent;
        bus.rsp_ready = 1'b0;
        send(4'b1101, 16'h1234, 16'h5678);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 16'h0) begin
            errors++; $display("FAIL abs_rsp: got v=%b e=%b d=%h expected 1/1/0000", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        checks++;
        if (bus.unit_en !== 4'b0 || bus.alu_in1 !== 16'h1234 || bus.alu_fun !== 2'b01 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL abs_bus: got en=%b in1=%h fun=%b busy=%b expected 0000/1234/01/1", bus.unit_en, bus.alu_in1, bus.alu_fun, bus.busy);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.alu_in1 !== 16'h0 || bus.unit_en !== 4'b0) begin
            errors++; $display("FAIL abs_done: got v=%b in1=%h en=%b expected 0/0000/0000", bus.rsp_valid, bus.alu_in1, bus.unit_en);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int w = 0;
        mute = 1'b1;
        bus.rsp_ready = 1'b1;
        send(4'b0100, 16'hAAAA, 16'h5555);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.unit_en !== 4'b0) begin
            errors++; $display("FAIL rm_ctrl: got busy=%b rdy=%b v=%b en=%b expected 0/1/0/0000", bus.busy, bus.cmd_ready, bus.rsp_valid, bus.unit_en);
        end
        checks++;
        if (bus.alu_in1 !== 16'h0 || bus.alu_in2 !== 16'h0 || bus.rsp_data !== 16'h0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL rm_data: got in1=%h in2=%h d=%h e=%b expected 0", bus.alu_in1, bus.alu_in2, bus.rsp_data, bus.rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mute = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rm_no_rsp: got %0d responses expected 0", seen);
        end
        send(4'b0100, 16'hFF00, 16'h0F0F);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (!bus.rsp_valid && w < 10) begin
            w++;
            @(negedge clk);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0F00 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL rm_after: got v=%b d=%h e=%b expected 1/0f00/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        int n = 0;
        logic [15:0] d [2];
        int c [2];
        bus.rsp_ready = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_stray: got busy=%b v=%b expected 0/0", bus.busy, bus.rsp_valid);
        end
        send(4'b0111, 16'hF0F0, 16'h0FF0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.unit_en != 4'b0) begin
                acc++;
                if (acc == 1) bus.cmd_op = 4'b0101;
                else bus.cmd_valid = 1'b0;
            end
            if (bus.rsp_valid && n < 2) begin
                d[n] = bus.rsp_data;
                c[n] = cyc;
                n++;
            end
        end
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL b2b_count: got %0d responses expected 2", n);
        end else begin
            checks++;
            if (d[0] !== 16'h000F || d[1] !== 16'hFFF0) begin
                errors++; $display("FAIL b2b_data: got %h %h expected 000f fff0", d[0], d[1]);
            end
            checks++;
            if (c[1] - c[0] !== 4) begin
                errors++; $display("FAIL b2b_spacing: got %0d expected 4", c[1] - c[0]);
            end
        end
    endtask

    initial begin
        stray = 1'b0;
        mute = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 4'b0;
        bus.cmd_a = 16'h0;
        bus.cmd_b = 16'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_logic_and;
        test_timeout;
        test_backpressure;
        test_absent;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
